// File: rtl/drp_responder_pkg.sv
// Shared definitions for the DRP responder: FSM states, STATUS address and layout.
package drp_responder_pkg;

    localparam int unsigned DrpAddrWidth = 7;
    localparam int unsigned DrpDataWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } drp_state_e;

    localparam logic [DrpAddrWidth-1:0] DrpStatusAddr = 7'h7F;

    localparam int unsigned StatusRangeBit   = 15;
    localparam int unsigned StatusOverlapBit = 14;

    function automatic logic [DrpDataWidth-1:0] status_word(input logic       range_err,
                                                            input logic       overlap_err,
                                                            input logic [7:0] count);
        logic [DrpDataWidth-1:0] w;
        w                   = '0;
        w[StatusRangeBit]   = range_err;
        w[StatusOverlapBit] = overlap_err;
        w[7:0]              = count;
        return w;
    endfunction

endpackage

// File: rtl/drp_responder_if.sv
// DRP bus between an initiator (master) and a responder (slave).
interface drp_responder_if;
    import drp_responder_pkg::*;

    logic [DrpAddrWidth-1:0] drp_addr;
    logic                    drp_den;
    logic                    drp_dwe;
    logic [DrpDataWidth-1:0] drp_din;
    logic [DrpDataWidth-1:0] drp_dout;
    logic                    drp_drdy;

    modport master (
        output drp_addr, drp_den, drp_dwe, drp_din,
        input  drp_dout, drp_drdy
    );

    modport slave (
        input  drp_addr, drp_den, drp_dwe, drp_din,
        output drp_dout, drp_drdy
    );

endinterface

// File: rtl/drp_latency_ctr.sv
// Loadable down-counter; terminal flags a count of one so the owner can act on the next edge.
module drp_latency_ctr #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == Width'(1));

endmodule

// File: rtl/drp_responder.sv
// DRP slave with fixed response latency, a 16-bit config register bank and sticky error STATUS.
module drp_responder
    import drp_responder_pkg::*;
#(
    parameter int unsigned pDEPTH   = 32,
    parameter int unsigned pLATENCY = 3
) (
    input  logic                  clk_usb,
    input  logic                  reset_n,
    drp_responder_if.slave        bus,
    output logic [pDEPTH*16-1:0]  cfg_regs,
    output logic [pDEPTH-1:0]     cfg_wr_pulse,
    output logic                  err_overlap,
    output logic                  err_range,
    input  logic                  err_clear
);

    localparam logic [3:0] CtrLoad    = 4'(pLATENCY - 1);
    localparam bit         DirectResp = (pLATENCY == 1);

    drp_state_e        state_q, state_d;
    logic [6:0]        addr_q;
    logic              dwe_q;
    logic [15:0]       din_q;
    logic [15:0]       regs_q [pDEPTH];
    logic [15:0]       dout_q;
    logic              drdy_q;
    logic [pDEPTH-1:0] wr_pulse_q, wr_onehot;
    logic              err_overlap_q, err_range_q;
    logic [7:0]        txn_count_q;

    logic        ctr_load, ctr_dec, ctr_terminal;
    logic        enter_resp, overlap_hit;
    logic [6:0]  txn_addr;
    logic        txn_dwe;
    logic [15:0] txn_din, rdata;
    logic        in_range, is_status, commit_wr, status_wr, range_hit, clear_any;

    drp_latency_ctr #(
        .Width (4)
    ) u_latency_ctr (
        .clk        (clk_usb),
        .rst_n      (reset_n),
        .load       (ctr_load),
        .load_value (CtrLoad),
        .dec        (ctr_dec),
        .terminal   (ctr_terminal)
    );

    always_comb begin
        state_d     = state_q;
        ctr_load    = 1'b0;
        ctr_dec     = 1'b0;
        enter_resp  = 1'b0;
        overlap_hit = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.drp_den) begin
                    ctr_load = 1'b1;
                    if (DirectResp) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                overlap_hit = bus.drp_den;
                if (ctr_terminal) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StResp: begin
                overlap_hit = bus.drp_den;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            dwe_q  <= 1'b0;
            din_q  <= '0;
        end else if ((state_q == StIdle) && bus.drp_den) begin
            addr_q <= bus.drp_addr;
            dwe_q  <= bus.drp_dwe;
            din_q  <= bus.drp_din;
        end
    end

    // With a latency of one, the commit edge is the DEN edge, so take the live bus values.
    assign txn_addr = (state_q == StIdle) ? bus.drp_addr : addr_q;
    assign txn_dwe  = (state_q == StIdle) ? bus.drp_dwe  : dwe_q;
    assign txn_din  = (state_q == StIdle) ? bus.drp_din  : din_q;

    assign in_range  = (32'(txn_addr) < pDEPTH);
    assign is_status = (txn_addr == DrpStatusAddr);
    assign commit_wr = enter_resp && txn_dwe && in_range;
    assign status_wr = enter_resp && txn_dwe && is_status;
    assign range_hit = enter_resp && !in_range && !is_status;
    assign clear_any = err_clear || status_wr;

    always_comb begin
        wr_onehot = '0;
        rdata     = '0;
        for (int unsigned i = 0; i < pDEPTH; i++) begin
            wr_onehot[i] = commit_wr && (txn_addr == 7'(i));
            if (txn_addr == 7'(i)) begin
                rdata = regs_q[i];
            end
        end
        if (is_status) begin
            rdata = status_word(err_range_q, err_overlap_q, txn_count_q);
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < pDEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < pDEPTH; i++) begin
                if (wr_onehot[i]) begin
                    regs_q[i] <= txn_din;
                end
            end
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            drdy_q        <= 1'b0;
            dout_q        <= '0;
            wr_pulse_q    <= '0;
            txn_count_q   <= '0;
            err_overlap_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            drdy_q        <= enter_resp;
            dout_q        <= (enter_resp && !txn_dwe) ? rdata : 16'h0000;
            wr_pulse_q    <= wr_onehot;
            if (state_q == StResp) begin
                txn_count_q <= txn_count_q + 8'd1;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            err_overlap_q <= overlap_hit || (err_overlap_q && !clear_any);
            err_range_q   <= range_hit || (err_range_q && !clear_any);
        end
    end

    always_comb begin
        cfg_regs = '0;
        for (int unsigned i = 0; i < pDEPTH; i++) begin
            cfg_regs[i*16 +: 16] = regs_q[i];
        end
    end

    assign bus.drp_dout  = dout_q;
    assign bus.drp_drdy  = drdy_q;
    assign cfg_wr_pulse  = wr_pulse_q;
    assign err_overlap   = err_overlap_q;
    assign err_range     = err_range_q;

endmodule
